// File: rtl/ysyx_24110015_rf_wb_arb.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_rf_wb_arb
//
// Purpose:
//   Shares the single register-file write port between two writeback sources
//   (wb0 = EXU result, wb1 = LSU load data). A round-robin arbiter picks one
//   request per cycle using a valid/ready handshake. The accepted request is
//   registered and drives the register file's wen/waddr/wdata on the
//   following cycle. A per-register pending scoreboard is set when decode
//   issues an instruction and cleared when its result commits, so decode can
//   detect RAW and WAW hazards.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   issue_valid/rd      decode reserves a destination register
//   issue_hazard        destination is already pending (WAW), x0 excluded
//   chk_rs1/rs2         source registers to check
//   raw_hazard          either source is pending (RAW), x0 excluded
//   wb0_valid/rd/data   EXU writeback request, wb0_ready = accepted
//   wb1_valid/rd/data   LSU writeback request, wb1_ready = accepted
//   rf_wen/waddr/wdata  registered register-file write port
//   pending             scoreboard bitmap, bit 0 is always 0
// ---------------------------------------------------------------------------
module ysyx_24110015_rf_wb_arb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     issue_valid,
  input  logic [ADDR_WIDTH-1:0]    issue_rd,
  output logic                     issue_hazard,

  input  logic [ADDR_WIDTH-1:0]    chk_rs1,
  input  logic [ADDR_WIDTH-1:0]    chk_rs2,
  output logic                     raw_hazard,

  input  logic                     wb0_valid,
  input  logic [ADDR_WIDTH-1:0]    wb0_rd,
  input  logic [DATA_WIDTH-1:0]    wb0_data,
  output logic                     wb0_ready,

  input  logic                     wb1_valid,
  input  logic [ADDR_WIDTH-1:0]    wb1_rd,
  input  logic [DATA_WIDTH-1:0]    wb1_data,
  output logic                     wb1_ready,

  output logic                     rf_wen,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic [2**ADDR_WIDTH-1:0] pending
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // Encoding of the last source that completed a handshake.
  typedef enum logic {
    SRC_WB0 = 1'b0,
    SRC_WB1 = 1'b1
  } src_e;

  src_e                  last_grant_q, last_grant_d;
  logic                  rf_wen_q,     rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q,   rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q,   rf_wdata_d;
  logic [NUM_REGS-1:0]   pending_q,    pending_d;

  logic                  grant0;
  logic                  grant1;
  logic                  handshake;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  // Round-robin arbiter. A lone request always wins; on a tie the source
  // that did not win the previous handshake goes first. Grants are only
  // ever raised for a valid request, so ready implies valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (wb0_valid && wb1_valid) begin
      grant0 = (last_grant_q == SRC_WB1);
      grant1 = (last_grant_q == SRC_WB0);
    end else begin
      grant0 = wb0_valid;
      grant1 = wb1_valid;
    end
  end

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;
  assign handshake = grant0 | grant1;

  // Payload of whichever source won this cycle.
  always_comb begin
    sel_rd   = wb0_rd;
    sel_data = wb0_data;
    if (grant1) begin
      sel_rd   = wb1_rd;
      sel_data = wb1_data;
    end
  end

  // Write stage: capture the accepted request. A write to x0 is accepted
  // (the source sees ready) but never raises wen. Without a handshake the
  // address and data hold so the port is quiet between writes.
  always_comb begin
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    last_grant_d = last_grant_q;
    if (handshake) begin
      rf_wen_d     = (sel_rd != '0);
      rf_waddr_d   = sel_rd;
      rf_wdata_d   = sel_data;
      last_grant_d = grant1 ? SRC_WB1 : SRC_WB0;
    end
  end

  // Scoreboard: the commit clear is applied before the issue set, so an
  // instruction reserving the same register that is committing this edge
  // keeps its reservation. x0 is never tracked.
  always_comb begin
    pending_d = pending_q;
    if (rf_wen_q) begin
      pending_d[rf_waddr_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers. Reset drops any in-flight write and leaves last_grant
  // pointing at wb1 so that wb0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      pending_q    <= '0;
      last_grant_q <= SRC_WB1;
    end else begin
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Hazard lookups read the current scoreboard; x0 never reports a hazard.
  assign issue_hazard = (issue_rd != '0) && pending_q[issue_rd];
  assign raw_hazard   = ((chk_rs1 != '0) && pending_q[chk_rs1]) ||
                        ((chk_rs2 != '0) && pending_q[chk_rs2]);

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign pending  = pending_q;

endmodule

// File: tb/tb_ysyx_24110015_rf_wb_arb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24110015_rf_wb_arb
//
// Self-checking bench for the writeback arbiter / scoreboard. A behavioural
// model tracks the expected write port, pending set and round-robin winner;
// a compare process checks every DUT output against it on each negedge.
// Directed sequences pin the model with literal expectations, then a random
// phase exercises contention, x0 writes, hazards and occasional resets.
// ---------------------------------------------------------------------------
module tb_ysyx_24110015_rf_wb_arb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_hazard;
  logic [AW-1:0] chk_rs1;
  logic [AW-1:0] chk_rs2;
  logic          raw_hazard;
  logic          wb0_valid;
  logic [AW-1:0] wb0_rd;
  logic [DW-1:0] wb0_data;
  logic          wb0_ready;
  logic          wb1_valid;
  logic [AW-1:0] wb1_rd;
  logic [DW-1:0] wb1_data;
  logic          wb1_ready;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [NR-1:0] pending;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state: what the write port and scoreboard must look like now.
  bit            m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  bit            m_pend [NR];
  int            m_last;
  bit            m_hs0;
  bit            m_hs1;

  always #5 clk = ~clk;

  ysyx_24110015_rf_wb_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_hazard (issue_hazard),
    .chk_rs1      (chk_rs1),
    .chk_rs2      (chk_rs2),
    .raw_hazard   (raw_hazard),
    .wb0_valid    (wb0_valid),
    .wb0_rd       (wb0_rd),
    .wb0_data     (wb0_data),
    .wb0_ready    (wb0_ready),
    .wb1_valid    (wb1_valid),
    .wb1_rd       (wb1_rd),
    .wb1_data     (wb1_data),
    .wb1_ready    (wb1_ready),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pending      (pending)
  );

  // Which source is served: the lone requester, or on a tie whichever
  // did not win last time. -1 means nobody.
  function automatic int winner(input bit v0, input bit v1, input int last);
    if (v0 && v1) return (last == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic logic [NR-1:0] model_pending();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit is_pending(input logic [AW-1:0] r);
    return (r != 0) && m_pend[r];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit iv, input logic [AW-1:0] ird,
                               input bit v0, input logic [AW-1:0] rd0, input logic [DW-1:0] d0,
                               input bit v1, input logic [AW-1:0] rd1, input logic [DW-1:0] d1);
    rst         = r;
    issue_valid = iv;
    issue_rd    = ird;
    wb0_valid   = v0;
    wb0_rd      = rd0;
    wb0_data    = d0;
    wb1_valid   = v1;
    wb1_rd      = rd1;
    wb1_data    = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model, advanced on every rising edge from the inputs seen there.
  always @(posedge clk) begin
    int w;
    w = winner(wb0_valid, wb1_valid, m_last);
    m_hs0 = (w == 0);
    m_hs1 = (w == 1);
    if (rst) begin
      m_wen   = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
      m_last  = 1;
      m_hs0   = 1'b1;
      m_hs1   = 1'b1;
    end else begin
      if (m_wen) m_pend[m_waddr] = 1'b0;
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      if (w >= 0) begin
        m_waddr = (w == 0) ? wb0_rd : wb1_rd;
        m_wdata = (w == 0) ? wb0_data : wb1_data;
        m_wen   = (m_waddr != 0);
        m_last  = w;
      end else begin
        m_wen = 1'b0;
      end
    end
  end

  // Compare process: every output against the model, away from the edge.
  always @(negedge clk) begin
    int w;
    if (check_en) begin
      w = winner(wb0_valid, wb1_valid, m_last);
      checkOutput("wb0_ready", 64'(wb0_ready), 64'(w == 0));
      checkOutput("wb1_ready", 64'(wb1_ready), 64'(w == 1));
      checkOutput("issue_hazard", 64'(issue_hazard), 64'(is_pending(issue_rd)));
      checkOutput("raw_hazard", 64'(raw_hazard),
                  64'(is_pending(chk_rs1) || is_pending(chk_rs2)));
      checkOutput("rf_wen", 64'(rf_wen), 64'(m_wen));
      checkOutput("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      checkOutput("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
      checkOutput("pending", 64'(pending), 64'(model_pending()));
    end
  end

  initial begin
    chk_rs1 = '0;
    chk_rs2 = '0;

    // Reset held two cycles with both sources requesting (rd 5 / rd 6).
    applyStimulus(1, 0, 0, 1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
    tick();
    check_en = 1'b1;
    tick();
    #1;
    checkOutput("reset_rf_wen", 64'(rf_wen), 64'd0);
    checkOutput("reset_pending", 64'(pending), 64'd0);

    // Release: wb0 wins the first tie, then wb1 on the next cycle.
    rst = 1'b0;
    #1;
    checkOutput("tie_wb0_ready", 64'(wb0_ready), 64'd1);
    checkOutput("tie_wb1_ready", 64'(wb1_ready), 64'd0);
    tick();
    wb0_valid = 1'b0;
    #1;
    checkOutput("cont_wen0", 64'(rf_wen), 64'd1);
    checkOutput("cont_addr0", 64'(rf_waddr), 64'd5);
    checkOutput("cont_data0", 64'(rf_wdata), 64'h11);
    checkOutput("cont_wb1_ready", 64'(wb1_ready), 64'd1);
    tick();
    wb1_valid = 1'b0;
    #1;
    checkOutput("cont_addr1", 64'(rf_waddr), 64'd6);
    checkOutput("cont_data1", 64'(rf_wdata), 64'h22);
    tick();
    #1;
    checkOutput("idle_wen", 64'(rf_wen), 64'd0);
    checkOutput("idle_addr_hold", 64'(rf_waddr), 64'd6);

    // x0 write: accepted but no write enable, pending[0] stays clear.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hDEAD);
    #1;
    checkOutput("x0_ready", 64'(wb1_ready), 64'd1);
    tick();
    wb1_valid = 1'b0;
    #1;
    checkOutput("x0_wen", 64'(rf_wen), 64'd0);
    checkOutput("x0_wdata", 64'(rf_wdata), 64'hDEAD);
    checkOutput("x0_pending0", 64'(pending[0]), 64'd0);

    // Scoreboard: issue x7, hazard until the commit edge has passed.
    applyStimulus(0, 1, 5'd7, 0, 0, 0, 0, 0, 0);
    tick();
    issue_valid = 1'b0;
    chk_rs1 = 5'd7;
    #1;
    checkOutput("sb_raw_set", 64'(raw_hazard), 64'd1);
    wb0_valid = 1'b1;
    wb0_rd    = 5'd7;
    wb0_data  = 32'h77;
    #1;
    checkOutput("sb_wb0_ready", 64'(wb0_ready), 64'd1);
    tick();
    wb0_valid = 1'b0;
    #1;
    checkOutput("sb_commit_wen", 64'(rf_wen), 64'd1);
    checkOutput("sb_raw_still", 64'(raw_hazard), 64'd1);
    tick();
    #1;
    checkOutput("sb_raw_clear", 64'(raw_hazard), 64'd0);
    chk_rs1 = '0;

    // Same-edge clear/set on x9: set wins.
    applyStimulus(0, 1, 5'd9, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 5'd9, 0, 0, 0, 1, 5'd9, 32'h99);
    tick();
    applyStimulus(0, 1, 5'd9, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("ss_wen", 64'(rf_wen), 64'd1);
    checkOutput("ss_issue_hazard", 64'(issue_hazard), 64'd1);
    tick();
    issue_valid = 1'b0;
    #1;
    checkOutput("ss_pending9", 64'(pending[9]), 64'd1);

    // Reset the cycle after a handshake drops the write and scoreboard.
    applyStimulus(0, 1, 5'd12, 1, 5'd3, 32'h33, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("mid_pre_wen", 64'(rf_wen), 64'd1);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("mid_wen", 64'(rf_wen), 64'd0);
    checkOutput("mid_pending", 64'(pending), 64'd0);
    checkOutput("mid_waddr", 64'(rf_waddr), 64'd0);
    applyStimulus(0, 0, 0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    #1;
    checkOutput("mid_tie_wb0", 64'(wb0_ready), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Random phase: sources hold their request until accepted.
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!wb0_valid || m_hs0) begin
        wb0_valid = ($urandom_range(0, 2) != 0);
        wb0_rd    = AW'($urandom_range(0, NR - 1));
        wb0_data  = DW'($urandom);
      end
      if (!wb1_valid || m_hs1) begin
        wb1_valid = ($urandom_range(0, 2) != 0);
        wb1_rd    = AW'($urandom_range(0, NR - 1));
        wb1_data  = DW'($urandom);
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = AW'($urandom_range(0, NR - 1));
      chk_rs1     = AW'($urandom_range(0, NR - 1));
      chk_rs2     = AW'($urandom_range(0, NR - 1));
      tick();
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
